seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
Multi-cycle magnitude comparator for WIDTH-bit unsigned operands. Walks the operands one 2-bit slice per clock, MSB slice first, and terminates early at the first differing slice. Produces the same one-hot Eq/Less/Greater result as the team's combinational 2-bit comparator, extended to wide words. Uses a start/busy/done handshake so upstream control logic can reuse one slice comparator in place of a wide combinational tree.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2 (slice count NS = WIDTH/2).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a comparison; sampled only when idle.
a  input  WIDTH  operand A, unsigned; captured on accepted start.
b  input  WIDTH  operand B, unsigned; captured on accepted start.
busy  output  1  high while a comparison is in progress.
done  output  1  single-cycle pulse; result valid and new this cycle.
Eq  output  1  A == B for the last completed comparison.
Less  output  1  A < B for the last completed comparison.
Greater  output  1  A > B for the last completed comparison.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, Eq=0, Less=0, Greater=0. Operand registers and slice index are cleared.
- Deasserting rst_n mid-comparison is the only abort path. The comparison is lost and no done is produced.
- States:
  - IDLE: busy=0. On start=1 at a rising edge: capture a/b into internal registers, set slice index to NS-1, clear Eq/Less/Greater to 0, go to COMPARE.
  - COMPARE: busy=1. Each cycle, compare slice a_r[2i+1:2i] against b_r[2i+1:2i] at the current index i.
    - Slices differ: set Less or Greater per the slice result and go to DONE.
    - Slices equal and i>0: decrement i and stay in COMPARE.
    - Slices equal and i==0: set Eq and go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle, then unconditionally go to IDLE. A start seen in DONE is ignored.
- Latency:
  - Start accepted at edge T. If the deciding slice is the k-th examined (k=1..NS), the result registers update at edge T+k and done is high during the cycle after edge T+k.
  - Best case k=1; worst case k=NS (operands equal, or differing only in slice 0).
- Results:
  - Eq/Less/Greater are exactly one-hot from the done cycle onward.
  - They hold their value through IDLE until the next accepted start, which clears all three to 0.
- Operand isolation: a/b are sampled only on the accepted start. Input changes while busy have no effect.
- Start handling:
  - start held high continuously launches back-to-back comparisons, one per (k+2) cycles. IDLE accepts it on the cycle after DONE.
  - A start pulse while busy or in DONE is dropped, not queued.
- Arithmetic: unsigned throughout. No sign handling. No X propagation on outputs after reset.

Test Plan:
- Reset: assert rst_n=0 with start=1 and random operands -> busy=0, done=0, Eq=Less=Greater=0. Release rst_n with start=0 -> all outputs remain 0.
- Early decision (WIDTH=8): a=8'hC0, b=8'h40, start for one cycle -> Greater=1 with done pulsing 1 cycle after acceptance (k=1), busy high for exactly 1 cycle.
- Worst-case equal: a=b=8'h5A -> busy high 4 cycles, then done=1 and Eq=1, Less=0, Greater=0. Outputs stay at that value for 10 idle cycles.
- LSB-slice difference: a=8'h12, b=8'h13 -> Less=1 after k=4. Changing a to 8'hFF on the cycle after start does not alter the result.
- Start while busy: a=8'h00, b=8'h01 accepted; on the next cycle pulse start with a=8'hFF, b=8'h00 -> only one done pulse occurs, with Less=1, and busy returns to 0.
- Async reset mid-compare: a=8'h01, b=8'h02 accepted; drop rst_n 2 cycles later -> all outputs 0 immediately, no done pulse. After release, an exhaustive 2-bit-slice sweep (all 16 MSB-slice pairs, lower bits equal) matches the expected Eq/Less/Greater.

Source files
------------

// File: rtl/seq_mag_comparator_if.sv
// rtl/seq_mag_comparator_if.sv - start/busy/done handshake and result bundle for seq_mag_comparator
//
// Signals:
//   start            request a comparison (master -> slave)
//   a, b             WIDTH-bit unsigned operands (master -> slave)
//   busy             comparison in progress (slave -> master)
//   done             one-cycle result-valid pulse (slave -> master)
//   Eq/Less/Greater  one-hot result of the last completed comparison (slave -> master)
interface seq_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             Eq;
  logic             Less;
  logic             Greater;

  modport master (
    output start, a, b,
    input  busy, done, Eq, Less, Greater
  );

  modport slave (
    input  start, a, b,
    output busy, done, Eq, Less, Greater
  );
endinterface

// File: rtl/seq_mag_comparator.sv
// rtl/seq_mag_comparator.sv - multi-cycle unsigned magnitude comparator, 2-bit slice per clock, MSB first
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   cmp    seq_mag_comparator_if.slave: start/a/b in, busy/done/Eq/Less/Greater out
//
// WIDTH must be even and >= 2; the operand is walked as WIDTH/2 two-bit slices.
module seq_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_mag_comparator_if.slave  cmp
);

  localparam int NS = WIDTH / 2;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  // Current slice selected by shifting the captured operand down by 2*idx.
  logic [1:0] a_sl;
  logic [1:0] b_sl;
  assign a_sl = 2'(a_q >> {idx_q, 1'b0});
  assign b_sl = 2'(b_q >> {idx_q, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;

    case (state_q)
      S_IDLE: begin
        if (cmp.start) begin
          a_d     = cmp.a;
          b_d     = cmp.b;
          idx_d   = IDX_TOP;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        // The first differing slice from the top decides the whole word.
        if (a_sl != b_sl) begin
          lt_d    = (a_sl < b_sl);
          gt_d    = (a_sl > b_sl);
          state_d = S_DONE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - IW'(1);
        end else begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end
      end

      // Single-cycle result pulse; any start seen here is dropped.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmp.busy    = (state_q == S_COMPARE);
  assign cmp.done    = (state_q == S_DONE);
  assign cmp.Eq      = eq_q;
  assign cmp.Less    = lt_q;
  assign cmp.Greater = gt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// tb/tb_seq_mag_comparator.sv - self-checking bench for seq_mag_comparator
module tb_seq_mag_comparator;

  logic clk;
  logic rst_n;

  seq_mag_comparator_if #(.WIDTH(8)) cmp_if ();

  seq_mag_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cmp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       eq;
    logic       lt;
    logic       gt;
    int         k;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0: plain; 1: change a to FF after acceptance; 2: pulse start with new operands while busy
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv, input int mode,
                         output int k_obs, output bit saw_done);
    @(negedge clk);
    cmp_if.a     = av;
    cmp_if.b     = bv;
    cmp_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp_if.start = 1'b0;
    if (mode == 1) cmp_if.a = 8'hFF;
    if (mode == 2) begin
      cmp_if.start = 1'b1;
      cmp_if.a     = 8'hFF;
      cmp_if.b     = 8'h00;
    end
    k_obs = 0;
    while (cmp_if.busy && k_obs < 40) begin
      k_obs++;
      @(negedge clk);
      cmp_if.start = 1'b0;
    end
    saw_done = cmp_if.done;
  endtask

  task automatic chk_result(input string name, input int k_obs, input bit saw_done,
                            input logic eq, input logic lt, input logic gt, input int k);
    chk({name, ".done"},    int'(saw_done),       1);
    chk({name, ".k"},       k_obs,                k);
    chk({name, ".Eq"},      int'(cmp_if.Eq),      int'(eq));
    chk({name, ".Less"},    int'(cmp_if.Less),    int'(lt));
    chk({name, ".Greater"}, int'(cmp_if.Greater), int'(gt));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".busy"},    int'(cmp_if.busy),    0);
    chk({name, ".done"},    int'(cmp_if.done),    0);
    chk({name, ".Eq"},      int'(cmp_if.Eq),      0);
    chk({name, ".Less"},    int'(cmp_if.Less),    0);
    chk({name, ".Greater"}, int'(cmp_if.Greater), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k_obs;
    bit  saw_done;
    int  cnt;
    int  gap;

    vecs[0]  = '{8'hC0, 8'h40, 1'b0, 1'b0, 1'b1, 1};
    vecs[1]  = '{8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 4};
    vecs[2]  = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 4};
    vecs[3]  = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 4};
    vecs[4]  = '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{8'h34, 8'h38, 1'b0, 1'b1, 1'b0, 3};
    vecs[7]  = '{8'hA7, 8'h97, 1'b0, 1'b0, 1'b1, 2};
    vecs[8]  = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 4};
    vecs[10] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 4};
    vecs[11] = '{8'h03, 8'h02, 1'b0, 1'b0, 1'b1, 4};

    // Reset held with start asserted and random operands.
    rst_n        = 1'b0;
    cmp_if.start = 1'b1;
    cmp_if.a     = 8'($urandom);
    cmp_if.b     = 8'($urandom);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    cmp_if.start = 1'b0;
    rst_n        = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("post_reset");

    // Table-driven vectors.
    foreach (vecs[i]) begin
      run_cmp(vecs[i].a, vecs[i].b, 0, k_obs, saw_done);
      chk_result($sformatf("vec%0d", i), k_obs, saw_done,
                 vecs[i].eq, vecs[i].lt, vecs[i].gt, vecs[i].k);
    end

    // Equal result holds through idle.
    run_cmp(8'h5A, 8'h5A, 0, k_obs, saw_done);
    chk_result("eq_hold", k_obs, saw_done, 1'b1, 1'b0, 1'b0, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("eq_hold.idle%0d", c),
          int'({cmp_if.busy, cmp_if.done, cmp_if.Eq, cmp_if.Less, cmp_if.Greater}), 5'b00100);
    end

    // Operand change after acceptance is ignored.
    run_cmp(8'h12, 8'h13, 1, k_obs, saw_done);
    chk_result("isolate", k_obs, saw_done, 1'b0, 1'b1, 1'b0, 4);

    // Start while busy is dropped: exactly one done pulse.
    run_cmp(8'h00, 8'h01, 2, k_obs, saw_done);
    chk_result("busy_start", k_obs, saw_done, 1'b0, 1'b1, 1'b0, 4);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cmp_if.done) cnt++;
    end
    chk("busy_start.extra_done", cnt, 0);
    chk("busy_start.busy", int'(cmp_if.busy), 0);

    // Start held high: back-to-back comparisons every k+2 cycles.
    @(negedge clk);
    cmp_if.a     = 8'hC0;
    cmp_if.b     = 8'h40;
    cmp_if.start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!cmp_if.done && cnt < 20);
    chk("b2b.first_done", int'(cmp_if.done), 1);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!cmp_if.done && gap < 20);
    chk("b2b.period", gap, 3);
    chk("b2b.Greater", int'(cmp_if.Greater), 1);
    cmp_if.start = 1'b0;
    repeat (4) @(negedge clk);

    // Leave a nonzero result, then abort a comparison with async reset.
    run_cmp(8'hFF, 8'h00, 0, k_obs, saw_done);
    chk_result("pre_abort", k_obs, saw_done, 1'b0, 1'b0, 1'b1, 1);
    @(negedge clk);
    cmp_if.a     = 8'h01;
    cmp_if.b     = 8'h02;
    cmp_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmp_if.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cmp_if.done) cnt++;
    end
    chk("abort.no_done", cnt, 0);
    chk("abort.busy", int'(cmp_if.busy), 0);

    // Sweep of all MSB-slice pairs with equal low bits.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [7:0] av;
        logic [7:0] bv;
        av = {2'(i), 6'h15};
        bv = {2'(j), 6'h15};
        run_cmp(av, bv, 0, k_obs, saw_done);
        chk_result($sformatf("sweep_%0d_%0d", i, j), k_obs, saw_done,
                   (i == j), (i < j), (i > j), (i == j) ? 4 : 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
